dioptase_alu: RTL and testbench

- Integer ALU of the Dioptase execute stage.
- Computes a combinational 32-bit result from opcode, alu_op, two operands and PC.
- Holds the architectural condition flags (C, Z, S, O) in a register; execute-stage branch logic reads them.
- Flags update only on committed ALU instructions.

---
 rtl/dioptase_alu.sv | 122 ++++++++++++
 tb/tb_dioptase_alu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dioptase_alu.sv
// Dioptase execute-stage integer ALU: combinational 32-bit result plus the
// registered architectural condition flags {O, S, Z, C}.
module dioptase_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [31:0] pc,
  input  logic        bubble,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [3:0]  flags_r;
  logic        cin_s;
  logic [4:0]  n_s;
  logic [32:0] shl_s;
  logic [32:0] shr_s;
  logic [32:0] asr_s;
  logic [31:0] rotl_s;
  logic [31:0] rotr_s;
  logic [31:0] lo_fill_s;
  logic [31:0] hi_fill_s;
  logic [31:0] add_b_s;
  logic        add_cin_s;
  logic [32:0] sum_s;
  logic [31:0] mul_s;
  logic [31:0] addr_sum_s;
  logic [31:0] alu_res_s;
  logic        c_s;
  logic        o_s;
  logic        upd_s;

  assign cin_s = flags_r[0];
  assign n_s   = rhs[4:0];

  // Extra guard bit on each shift captures the last bit shifted out; it is 0 when n=0.
  assign shl_s     = {1'b0, lhs} << n_s;
  assign shr_s     = {lhs, 1'b0} >> n_s;
  assign asr_s     = $signed({lhs, 1'b0}) >>> n_s;
  assign rotl_s    = (lhs << n_s) | (lhs >> (6'd32 - {1'b0, n_s}));
  assign rotr_s    = (lhs >> n_s) | (lhs << (6'd32 - {1'b0, n_s}));
  assign lo_fill_s = cin_s ? ~(32'hFFFF_FFFF << n_s) : 32'h0000_0000;
  assign hi_fill_s = cin_s ? ~(32'hFFFF_FFFF >> n_s) : 32'h0000_0000;

  assign sum_s      = {1'b0, lhs} + {1'b0, add_b_s} + {32'd0, add_cin_s};
  assign mul_s      = lhs * rhs;
  assign addr_sum_s = lhs + rhs;

  // Adder operand and carry-in select: subtraction adds the complement of rhs.
  always_comb begin
    add_b_s   = rhs;
    add_cin_s = 1'b0;
    case (alu_op)
      5'd15:   add_cin_s = cin_s;
      5'd16:   begin add_b_s = ~rhs; add_cin_s = 1'b1;  end
      5'd17:   begin add_b_s = ~rhs; add_cin_s = cin_s; end
      default: begin add_b_s = rhs;  add_cin_s = 1'b0;  end
    endcase
  end

  // ALU function decode with carry and overflow for the flag update.
  always_comb begin
    alu_res_s = 32'h0000_0000;
    c_s       = 1'b0;
    o_s       = 1'b0;
    case (alu_op)
      5'd0:  alu_res_s = lhs & rhs;
      5'd1:  alu_res_s = ~(lhs & rhs);
      5'd2:  alu_res_s = lhs | rhs;
      5'd3:  alu_res_s = ~(lhs | rhs);
      5'd4:  alu_res_s = lhs ^ rhs;
      5'd5:  alu_res_s = ~(lhs ^ rhs);
      5'd6:  alu_res_s = ~rhs;
      5'd7:  begin alu_res_s = shl_s[31:0];             c_s = shl_s[32]; end
      5'd8:  begin alu_res_s = shr_s[32:1];             c_s = shr_s[0];  end
      5'd9:  begin alu_res_s = asr_s[32:1];             c_s = asr_s[0];  end
      5'd10: begin alu_res_s = rotl_s; c_s = (n_s != 5'd0) & rotl_s[0];  end
      5'd11: begin alu_res_s = rotr_s; c_s = (n_s != 5'd0) & rotr_s[31]; end
      5'd12: begin alu_res_s = shl_s[31:0] | lo_fill_s; c_s = shl_s[32]; end
      5'd13: begin alu_res_s = shr_s[32:1] | hi_fill_s; c_s = shr_s[0];  end
      5'd14, 5'd15, 5'd16, 5'd17: begin
        alu_res_s = sum_s[31:0];
        c_s       = sum_s[32];
        o_s       = (lhs[31] == add_b_s[31]) && (sum_s[31] != lhs[31]);
      end
      5'd18:   alu_res_s = mul_s;
      default: alu_res_s = 32'h0000_0000;
    endcase
  end

  // Result mux by instruction class.
  always_comb begin
    result = 32'h0000_0000;
    case (opcode)
      5'd0, 5'd1: result = alu_res_s;
      5'd2:       result = rhs;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
      5'd12, 5'd13, 5'd14: result = addr_sum_s;
      5'd22:      result = pc + 32'd4 + rhs;
      default:    result = 32'h0000_0000;
    endcase
  end

  assign upd_s = !bubble && ((opcode == 5'd0) || (opcode == 5'd1)) && (alu_op <= 5'd18);

  // Flag register: loads only on committed ALU instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (upd_s) begin
      flags_r <= {o_s, alu_res_s[31], (alu_res_s == 32'h0000_0000), c_s};
    end else begin
      flags_r <= flags_r;
    end
  end

  assign flags = flags_r;

endmodule

// File: tb/tb_dioptase_alu.sv
// Scoreboard bench for dioptase_alu: a bit-serial reference model pushes
// expected result/flags per instruction; each test pops and compares.
module tb_dioptase_alu;

  logic        clk;
  logic        rst_n;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [31:0] pc;
  logic        bubble;
  logic [31:0] result;
  logic [3:0]  flags;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  aop;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] p;
    logic        b;
  } stim_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_flags;
  int         checks;
  int         errors;

  dioptase_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .alu_op (alu_op),
    .lhs    (lhs),
    .rhs    (rhs),
    .pc     (pc),
    .bubble (bubble),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: shifts done one bit at a time, overflow from a 64-bit signed sum.
  function automatic void model(input logic [4:0] op, input logic [4:0] aop,
                                input logic [31:0] l, input logic [31:0] r,
                                input logic [31:0] p, input logic [3:0] f,
                                input logic b, output logic [31:0] res,
                                output logic [3:0] nf);
    logic [31:0] v;
    logic [31:0] bb;
    logic [32:0] u;
    logic        c;
    logic        o;
    logic        ci;
    logic        upd;
    longint      s;
    c = 1'b0; o = 1'b0; upd = 1'b0; res = 32'd0;
    if (op == 5'd0 || op == 5'd1) begin
      upd = (aop <= 5'd18);
      if      (aop == 5'd0) res = l & r;
      else if (aop == 5'd1) res = ~(l & r);
      else if (aop == 5'd2) res = l | r;
      else if (aop == 5'd3) res = ~(l | r);
      else if (aop == 5'd4) res = l ^ r;
      else if (aop == 5'd5) res = ~(l ^ r);
      else if (aop == 5'd6) res = ~r;
      else if (aop >= 5'd7 && aop <= 5'd13) begin
        v = l;
        for (int i = 0; i < int'(r[4:0]); i++) begin
          case (aop)
            5'd7:    begin c = v[31]; v = {v[30:0], 1'b0};  end
            5'd8:    begin c = v[0];  v = {1'b0, v[31:1]};  end
            5'd9:    begin c = v[0];  v = {v[31], v[31:1]}; end
            5'd10:   begin c = v[31]; v = {v[30:0], v[31]}; end
            5'd11:   begin c = v[0];  v = {v[0], v[31:1]};  end
            5'd12:   begin c = v[31]; v = {v[30:0], f[0]};  end
            default: begin c = v[0];  v = {f[0], v[31:1]};  end
          endcase
        end
        res = v;
      end else if (aop >= 5'd14 && aop <= 5'd17) begin
        bb = (aop >= 5'd16) ? ~r : r;
        ci = (aop == 5'd14) ? 1'b0 : (aop == 5'd16) ? 1'b1 : f[0];
        u  = {1'b0, l} + {1'b0, bb} + {32'd0, ci};
        res = u[31:0];
        c   = u[32];
        s   = longint'($signed(l)) + longint'($signed(bb)) + longint'(ci);
        o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (aop == 5'd18) res = l * r;
    end else if (op == 5'd2) res = r;
    else if (op >= 5'd3 && op <= 5'd14) res = l + r;
    else if (op == 5'd22) res = p + 32'd4 + r;
    nf = f;
    if (!b && upd) nf = {o, res[31], (res == 32'd0), c};
  endfunction

  task automatic issue(input stim_t s);
    exp_t e;
    opcode = s.op; alu_op = s.aop; lhs = s.l; rhs = s.r; pc = s.p; bubble = s.b;
    model(s.op, s.aop, s.l, s.r, s.p, model_flags, s.b, e.res, e.flg);
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; opcode = 5'd0; alu_op = 5'd16; lhs = 32'd5; rhs = 32'd5;
    pc = 32'd0; bubble = 1'b0; model_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", flags);
    end
    @(negedge clk); rst_n = 1'b1; opcode = 5'd31;
    @(posedge clk); #1;
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL after_reset_flags got %b want 0000", flags);
    end
  endtask

  task automatic test_pass_and_mem;
    stim_t v[4];
    exp_t  e;
    v[0] = '{5'd2,  5'd0, 32'hDEAD_BEEF, 32'h1234_5000, 32'h0,  1'b0};
    v[1] = '{5'd3,  5'd0, 32'h0000_0100, 32'h0000_0008, 32'h0,  1'b0};
    v[2] = '{5'd22, 5'd0, 32'h0,         32'h0000_0010, 32'h40, 1'b0};
    v[3] = '{5'd14, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,  1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(v[i]);
      @(negedge clk); e = sb.pop_front();
      checks++;
      if (result !== e.res) begin
        errors++; $display("FAIL pass_mem_result[%0d] got %h want %h", i, result, e.res);
      end
      @(posedge clk); #1;
      checks++;
      if (flags !== e.flg) begin
        errors++; $display("FAIL pass_mem_flags[%0d] got %b want %b", i, flags, e.flg);
      end
      model_flags = e.flg;
    end
  endtask

  task automatic test_arith;
    stim_t v[8];
    exp_t  e;
    v[0] = '{5'd0, 5'd16, 32'd5,         32'd5,         32'h0, 1'b0};
    v[1] = '{5'd0, 5'd16, 32'd3,         32'd5,         32'h0, 1'b0};
    v[2] = '{5'd1, 5'd14, 32'h7FFF_FFFF, 32'd1,         32'h0, 1'b0};
    v[3] = '{5'd1, 5'd14, 32'hFFFF_FFFF, 32'd1,         32'h0, 1'b0};
    v[4] = '{5'd1, 5'd15, 32'd1,         32'd1,         32'h0, 1'b0};
    v[5] = '{5'd1, 5'd14, 32'hFFFF_FFFF, 32'd1,         32'h0, 1'b0};
    v[6] = '{5'd1, 5'd12, 32'd1,         32'd4,         32'h0, 1'b0};
    v[7] = '{5'd0, 5'd17, 32'h8000_0000, 32'd1,         32'h0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      issue(v[i]);
      @(negedge clk); e = sb.pop_front();
      checks++;
      if (result !== e.res) begin
        errors++; $display("FAIL arith_result[%0d] got %h want %h", i, result, e.res);
      end
      @(posedge clk); #1;
      checks++;
      if (flags !== e.flg) begin
        errors++; $display("FAIL arith_flags[%0d] got %b want %b", i, flags, e.flg);
      end
      model_flags = e.flg;
    end
  endtask

  task automatic test_shift;
    stim_t v[8];
    exp_t  e;
    v[0] = '{5'd0, 5'd7,  32'h8000_0001, 32'd1,  32'h0, 1'b0};
    v[1] = '{5'd0, 5'd9,  32'h8000_0000, 32'd4,  32'h0, 1'b0};
    v[2] = '{5'd0, 5'd11, 32'h0000_0001, 32'd1,  32'h0, 1'b0};
    v[3] = '{5'd0, 5'd13, 32'hF000_0000, 32'd8,  32'h0, 1'b0};
    v[4] = '{5'd0, 5'd10, 32'h8000_0001, 32'd0,  32'h0, 1'b0};
    v[5] = '{5'd0, 5'd8,  32'h0000_00F1, 32'd31, 32'h0, 1'b0};
    v[6] = '{5'd0, 5'd10, 32'hC000_0000, 32'd3,  32'h0, 1'b0};
    v[7] = '{5'd0, 5'd18, 32'h0001_0003, 32'h0001_0005, 32'h0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      issue(v[i]);
      @(negedge clk); e = sb.pop_front();
      checks++;
      if (result !== e.res) begin
        errors++; $display("FAIL shift_result[%0d] got %h want %h", i, result, e.res);
      end
      @(posedge clk); #1;
      checks++;
      if (flags !== e.flg) begin
        errors++; $display("FAIL shift_flags[%0d] got %b want %b", i, flags, e.flg);
      end
      model_flags = e.flg;
    end
  endtask

  task automatic test_no_update;
    stim_t v[5];
    exp_t  e;
    v[0] = '{5'd0,  5'd16, 32'd3,     32'd5,     32'h0,  1'b0};
    v[1] = '{5'd0,  5'd16, 32'd7,     32'd7,     32'h0,  1'b1};
    v[2] = '{5'd1,  5'd19, 32'd0,     32'd0,     32'h0,  1'b0};
    v[3] = '{5'd3,  5'd16, 32'h100,   32'd8,     32'h0,  1'b0};
    v[4] = '{5'd22, 5'd14, 32'h0,     32'h10,    32'h40, 1'b0};
    for (int i = 0; i < 5; i++) begin
      issue(v[i]);
      @(negedge clk); e = sb.pop_front();
      checks++;
      if (result !== e.res) begin
        errors++; $display("FAIL hold_result[%0d] got %h want %h", i, result, e.res);
      end
      @(posedge clk); #1;
      checks++;
      if (flags !== e.flg) begin
        errors++; $display("FAIL hold_flags[%0d] got %b want %b", i, flags, e.flg);
      end
      model_flags = e.flg;
    end
  endtask

  task automatic test_back_to_back;
    stim_t s;
    exp_t  e;
    int    pick;
    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 9);
      if      (pick <= 5) s.op = 5'($urandom_range(0, 1));
      else if (pick == 6) s.op = 5'd2;
      else if (pick == 7) s.op = 5'($urandom_range(3, 14));
      else if (pick == 8) s.op = 5'd22;
      else                s.op = 5'($urandom_range(0, 31));
      s.aop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
      s.l = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : 32'($urandom);
      s.r = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'($urandom);
      s.p = 32'($urandom);
      s.b = ($urandom_range(0, 7) == 0);
      issue(s);
      @(negedge clk); e = sb.pop_front();
      checks++;
      if (result !== e.res) begin
        errors++; $display("FAIL b2b_result[%0d] op %0d aop %0d got %h want %h", i, s.op, s.aop, result, e.res);
      end
      @(posedge clk); #1;
      checks++;
      if (flags !== e.flg) begin
        errors++; $display("FAIL b2b_flags[%0d] op %0d aop %0d got %b want %b", i, s.op, s.aop, flags, e.flg);
      end
      model_flags = e.flg;
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    issue('{5'd0, 5'd16, 32'd5, 32'd5, 32'h0, 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    model_flags = e.flg;
    checks++;
    if (flags !== 4'b0011) begin
      errors++; $display("FAIL pre_reset_flags got %b want 0011", flags);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL async_reset_flags got %b want 0000", flags);
    end
    issue('{5'd0, 5'd16, 32'd3, 32'd5, 32'h0, 1'b0});
    void'(sb.pop_front());
    @(posedge clk); #1;
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL reset_priority_flags got %b want 0000", flags);
    end
    @(negedge clk); rst_n = 1'b1; model_flags = 4'b0000; opcode = 5'd31;
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pass_and_mem();
    test_arith();
    test_shift();
    test_no_update();
    test_back_to_back();
    test_reset_mid();
    test_arith();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
